// File: rtl/program_selector.sv
// Program-select front end: synchronised, hold-qualified next/prev buttons step a wrapping index.
// Optional auto-repeat while a single button is held: define PROGRAM_SELECTOR_AUTO_REPEAT_EN.
module program_selector #(
  parameter int unsigned NUM_PROGRAMS  = 16,
  parameter int unsigned PROG_W        = 4,
  parameter int unsigned CNT_W         = 24,
  parameter int unsigned HOLD_CYCLES   = 16777215,
  parameter int unsigned REPEAT_CYCLES = 8388608
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              btn_next,
  input  logic              btn_prev,
  output logic [PROG_W-1:0] program_choosen,
  output logic              program_changed,
  output logic              busy
);

  if (NUM_PROGRAMS < 2 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 1) begin : g_bad_params
    $error("program_selector: illegal parameter set");
  end

  localparam logic [PROG_W-1:0] LastIdx  = PROG_W'(NUM_PROGRAMS - 1);
  localparam logic [CNT_W-1:0]  HoldLast = CNT_W'(HOLD_CYCLES - 1);
`ifdef PROGRAM_SELECTOR_AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0]  RepLast  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  localparam logic [1:0] KeyNone  = 2'b00;
  localparam logic [1:0] KeyPrev  = 2'b01;
  localparam logic [1:0] KeyNext  = 2'b10;
  localparam logic [1:0] KeyChord = 2'b11;

  typedef enum logic [1:0] {StIdle, StCount, StRepeat, StWaitRel} state_e;

  state_e            state_q, state_d;
  logic [1:0]        sync1_q, sync2_q;
  logic [1:0]        key;
  logic [1:0]        key_q, key_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PROG_W-1:0] idx_q, idx_d;
  logic              changed_q;
  logic              act;

  assign key = sync2_q;

  // State register plus the index/pulse registers updated by an action.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q   <= KeyNone;
      sync2_q   <= KeyNone;
      state_q   <= StIdle;
      key_q     <= KeyNone;
      cnt_q     <= '0;
      idx_q     <= '0;
      changed_q <= 1'b0;
    end else begin
      sync1_q   <= {btn_next, btn_prev};
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      key_q     <= key_d;
      cnt_q     <= cnt_d;
      changed_q <= act;
      if (act) idx_q <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (key != KeyNone) begin
          key_d   = key;
          cnt_d   = CNT_W'(1);
          state_d = StCount;
        end
      end
      StCount: begin
        if (key == KeyNone) begin
          state_d = StIdle;
        end else if (key != key_q) begin
          // Stagger or chord forming: restart qualification on the new key.
          key_d = key;
          cnt_d = CNT_W'(1);
        end else if (cnt_q == HoldLast) begin
`ifdef PROGRAM_SELECTOR_AUTO_REPEAT_EN
          if (key != KeyChord) begin
            state_d = StRepeat;
            cnt_d   = '0;
          end else begin
            state_d = StWaitRel;
          end
`else
          state_d = StWaitRel;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef PROGRAM_SELECTOR_AUTO_REPEAT_EN
      StRepeat: begin
        if (key != key_q) begin
          state_d = StWaitRel;
        end else if (cnt_q == RepLast) begin
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      StWaitRel: begin
        if (key == KeyNone) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    act  = 1'b0;
    busy = (state_q != StIdle);
    unique case (state_q)
      StCount:  act = (key == key_q) && (cnt_q == HoldLast);
`ifdef PROGRAM_SELECTOR_AUTO_REPEAT_EN
      StRepeat: act = (key == key_q) && (cnt_q == RepLast);
`endif
      default:  act = 1'b0;
    endcase

    idx_d = idx_q;
    unique case (key_q)
      KeyNext:  idx_d = (idx_q == LastIdx) ? '0 : idx_q + PROG_W'(1);
      KeyPrev:  idx_d = (idx_q == '0) ? LastIdx : idx_q - PROG_W'(1);
      KeyChord: idx_d = '0;
      default:  idx_d = idx_q;
    endcase
  end

  assign program_choosen = idx_q;
  assign program_changed = changed_q;

endmodule

// File: doc/program_selector.md
# program_selector

Parametrised program-selection front end for the LED pattern engine. Two push-buttons (next/prev) are synchronised and hold-qualified; a qualified press steps a wrap-around program index up or down, and a two-button chord returns it to program 0. An optional auto-repeat steps the index periodically while a button stays held. The block drives the pattern engine's program select and flags every change with a one-cycle pulse.

## Interface
- `NUM_PROGRAMS`, 16: number of programs; legal index 0..NUM_PROGRAMS-1; ≥2.
- `PROG_W`, 4: index width; ≥ clog2(NUM_PROGRAMS).
- `CNT_W`, 24: hold/repeat counter width.
- `HOLD_CYCLES`, 16777215: consecutive sampled-high cycles that qualify a press; 2 ≤ HOLD_CYCLES < 2^CNT_W.
- `REPEAT_CYCLES`, 8388608: auto-repeat period in cycles; 1 ≤ REPEAT_CYCLES < 2^CNT_W.

- `clk` in 1: system clock; single clock domain.
- `rst_n` in 1: reset, synchronous, active-low.
- `btn_next` in 1: raw asynchronous button, active-high.
- `btn_prev` in 1: raw asynchronous button, active-high.
- `program_choosen` out PROG_W: current program index, registered.
- `program_changed` out 1: one-cycle pulse, same edge as each index update.
- `busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- Each button passes through a 2-FF synchroniser; `key` = {next_s, prev_s}. The FSM sees only `key`.
- FSM states: IDLE, COUNT, REPEAT, WAIT_REL. `key_q` holds the captured key.
- IDLE: when key≠0, key_q←key, cnt←1, go to COUNT.
- COUNT, key==key_q: if cnt==HOLD_CYCLES-1, perform the action (this edge takes the HOLD_CYCLES-th consecutive sample) and go to REPEAT (macro on, single key) or WAIT_REL; otherwise cnt++.
- COUNT, key==0: go to IDLE with no action.
- COUNT, key≠0 and key≠key_q (stagger or chord forming): key_q←key, cnt←1, stay in COUNT.
- REPEAT: if key==key_q, cnt++; when cnt==REPEAT_CYCLES-1, repeat the action and clear cnt. Any key change goes to WAIT_REL.
- WAIT_REL: go to IDLE when key==0. Nothing else has any effect.
- Actions:
  - next: index==NUM_PROGRAMS-1 → 0, else +1.
  - prev: index==0 → NUM_PROGRAMS-1, else −1.
  - chord (both buttons): index←0.
  - Every action pulses `program_changed`, including a chord when the index is already 0.
- Chords never auto-repeat.
- Index arithmetic is done in PROG_W bits. The index never leaves 0..NUM_PROGRAMS-1.

## Timing
- Reset: program_choosen=0, program_changed=0, busy=0. The synchroniser, cnt and key_q clear, and the FSM goes to IDLE.
- A button still held when reset releases is a new press and must requalify for the full HOLD_CYCLES.
- Latency: if a button rises before edge 1, the first action occurs on edge HOLD_CYCLES+2. `program_choosen` and `program_changed` change on that same edge.
- Auto-repeat actions follow every REPEAT_CYCLES edges after the first action while key is unchanged.
- A release lasting even one sampled cycle during COUNT aborts the press with no partial credit.
- `program_changed` is never high on two consecutive edges unless REPEAT_CYCLES=1.

## Configuration
- `PROGRAM_SELECTOR_AUTO_REPEAT_EN`
  - Defined: single-key presses enter REPEAT after the first action and step every REPEAT_CYCLES while held.
  - Undefined: every qualified press performs exactly one action, then WAIT_REL. The REPEAT state and the REPEAT_CYCLES logic are not built, and REPEAT_CYCLES is ignored.

## Test plan
Bench parameters: NUM_PROGRAMS=8, HOLD_CYCLES=4, REPEAT_CYCLES=3, PROG_W=3, CNT_W=8. Buttons rise before edge 1.
- btn_next high for edges 1–17, macro off → index 0→1 at edge 6, one pulse. busy stays high until key==0 is seen, then falls.
- Same stimulus, macro on → steps at edges 6, 9, 12, 15, 18 → index 5, five pulses.
- Glitch: btn_next high for edges 1–3 only → no change, no pulse; busy returns low.
- Wrap: from index 7, qualified next → 0. From 0, qualified prev → 7.
- Chord: index 5; btn_next rises, btn_prev rises 2 cycles later; both held → index 0 with one pulse, 4 samples after the chord is first seen. No repeat with macro on.
- Reset mid-hold: assert rst_n=0 at edge 4 of a next press, release at edge 6 with button still high → index stays 0 and busy=0 during reset. After release, the press requalifies and index becomes 1 at edge HOLD_CYCLES+2 counted from the release.
